// File: rtl/ssb_sync_controller_if.sv
// Handshake/data bundle between the SSB sync controller and its neighbours:
// PSS detector, FFT demodulator and SSS detector.
interface ssb_sync_controller_if;
  // towards the controller
  logic       s_axis_in_tvalid;
  logic       peak_detected_i;
  logic [1:0] N_id_2_i;
  logic       SSS_start_i;
  logic       SSS_valid_i;
  logic [8:0] N_id_1_i;
  logic       N_id_1_valid_i;
  // from the controller
  logic       SSB_start_o;
  logic [1:0] N_id_2_o;
  logic       N_id_2_valid_o;
  logic       SSS_valid_o;
  logic [9:0] N_id_o;
  logic       N_id_valid_o;
  logic       locked_o;
  logic       timeout_o;
  logic [2:0] state_o;

  // controller side
  modport slave (
    input  s_axis_in_tvalid, peak_detected_i, N_id_2_i, SSS_start_i,
           SSS_valid_i, N_id_1_i, N_id_1_valid_i,
    output SSB_start_o, N_id_2_o, N_id_2_valid_o, SSS_valid_o, N_id_o,
           N_id_valid_o, locked_o, timeout_o, state_o
  );

  // environment side
  modport master (
    output s_axis_in_tvalid, peak_detected_i, N_id_2_i, SSS_start_i,
           SSS_valid_i, N_id_1_i, N_id_1_valid_i,
    input  SSB_start_o, N_id_2_o, N_id_2_valid_o, SSS_valid_o, N_id_o,
           N_id_valid_o, locked_o, timeout_o, state_o
  );
endinterface

// File: rtl/ssb_sync_controller.sv
// SSB sync controller: accepts PSS peaks, triggers the FFT demodulator,
// windows the SSS subcarriers into the SSS detector, forms N_id and tracks
// SSB periodicity once locked.
module ssb_sync_controller #(
  parameter int SSS_START   = 64,
  parameter int SSS_LEN     = 127,
  parameter int SSB_PERIOD  = 76800,
  parameter int WINDOW_HALF = 8,
  parameter int MAX_MISSES  = 3,
  parameter int SSS_TIMEOUT = 4096
) (
  input logic             clk_i,
  input logic             reset_ni,
  ssb_sync_controller_if.slave bus
);

  localparam int SCW     = $clog2(SSB_PERIOD + WINDOW_HALF + 1);
  localparam int SSS_MAX = (SSS_START > SSS_LEN) ? SSS_START : SSS_LEN;
  localparam int SSW     = $clog2(SSS_MAX + 1);
  localparam int TOW     = $clog2(SSS_TIMEOUT + 1);
  localparam int MW      = $clog2(MAX_MISSES + 1);

  localparam logic [SCW-1:0] WIN_OPEN     = SCW'(SSB_PERIOD - WINDOW_HALF);
  localparam logic [SCW-1:0] WIN_CLOSE    = SCW'(SSB_PERIOD + WINDOW_HALF);
  localparam logic [SCW-1:0] WIN_RECENTER = SCW'(WINDOW_HALF);
  localparam logic [SSW-1:0] SKIP_LAST    = SSW'(SSS_START - 1);
  localparam logic [SSW-1:0] PASS_LAST    = SSW'(SSS_LEN - 1);
  localparam logic [TOW-1:0] TO_LIMIT     = TOW'(SSS_TIMEOUT);
  localparam logic [MW-1:0]  MISS_LAST    = MW'(MAX_MISSES - 1);

  typedef enum logic [2:0] {
    SEARCH     = 3'd0,
    WAIT_SYM   = 3'd1,
    SKIP       = 3'd2,
    PASS       = 3'd3,
    WAIT_NID1  = 3'd4,
    TRACK_WAIT = 3'd5,
    TRACK_WIN  = 3'd6
  } state_t;

  state_t         state, state_nxt;
  logic [SCW-1:0] sample_cnt;
  logic [SSW-1:0] sss_cnt;
  logic [TOW-1:0] to_cnt;
  logic [MW-1:0]  miss_cnt;

  logic       ssb_start_q, n_id_2_valid_q, n_id_valid_q, locked_q, timeout_q;
  logic [1:0] n_id_2_q;
  logic [9:0] n_id_q;

  // decoded events for the current cycle
  logic       accept, in_acq, nid_hit, nid_ok, to_hit, win_end, miss_last;
  logic       skip_done, pass_done;
  logic [SCW-1:0] sample_nxt;
  logic [9:0] nid_calc;

  // Event decode shared by the next-state logic and the datapath.
  always_comb begin
    accept     = bus.peak_detected_i &&
                 ((state == SEARCH) ||
                  ((state == TRACK_WIN) && (bus.N_id_2_i == n_id_2_q)));
    in_acq     = (state == WAIT_SYM) || (state == SKIP) ||
                 (state == PASS) || (state == WAIT_NID1);
    nid_hit    = (state == WAIT_NID1) && bus.N_id_1_valid_i;
    // 10-bit wrap is intentional: out-of-range N_id_1 is not screened
    nid_calc   = ({1'b0, bus.N_id_1_i} << 1) + {1'b0, bus.N_id_1_i} +
                 {8'd0, n_id_2_q};
    nid_ok     = !locked_q || (nid_calc == n_id_q);
    // a detector result on the limit cycle takes priority over the timeout
    to_hit     = in_acq && (to_cnt == TO_LIMIT) && !nid_hit;
    // a peak on the window-end cycle is accepted instead of counting a miss
    win_end    = (state == TRACK_WIN) && (sample_cnt == WIN_CLOSE) && !accept;
    miss_last  = win_end && (miss_cnt == MISS_LAST);
    skip_done  = (state == SKIP) && bus.SSS_valid_i && (sss_cnt == SKIP_LAST);
    pass_done  = (state == PASS) && bus.SSS_valid_i && (sss_cnt == PASS_LAST);
    sample_nxt = sample_cnt + {{(SCW-1){1'b0}}, bus.s_axis_in_tvalid};
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= SEARCH;
    else           state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:     if (accept) state_nxt = WAIT_SYM;
      WAIT_SYM:   if (to_hit) state_nxt = SEARCH;
                  else if (bus.SSS_start_i) state_nxt = SKIP;
      SKIP:       if (to_hit) state_nxt = SEARCH;
                  else if (skip_done) state_nxt = PASS;
      PASS:       if (to_hit) state_nxt = SEARCH;
                  else if (pass_done) state_nxt = WAIT_NID1;
      WAIT_NID1:  if (nid_hit) state_nxt = nid_ok ? TRACK_WAIT : SEARCH;
                  else if (to_hit) state_nxt = SEARCH;
      // enter the window exactly when the counter reaches its opening value
      TRACK_WAIT: if (sample_nxt == WIN_OPEN) state_nxt = TRACK_WIN;
      TRACK_WIN:  if (accept) state_nxt = WAIT_SYM;
                  else if (win_end) state_nxt = miss_last ? SEARCH : TRACK_WAIT;
      default:    state_nxt = SEARCH;
    endcase
  end

  // Outputs: registered pulses/values, plus the zero-latency SSS gate that
  // must stay aligned with the demodulator data bus.
  always_comb begin
    bus.SSB_start_o    = ssb_start_q;
    bus.N_id_2_o       = n_id_2_q;
    bus.N_id_2_valid_o = n_id_2_valid_q;
    bus.SSS_valid_o    = (state == PASS) && bus.SSS_valid_i;
    bus.N_id_o         = n_id_q;
    bus.N_id_valid_o   = n_id_valid_q;
    bus.locked_o       = locked_q;
    bus.timeout_o      = timeout_q;
    bus.state_o        = state;
  end

  // Sample counter: phase reference for the SSB period.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)
      sample_cnt <= '0;
    else if (accept)
      sample_cnt <= {{(SCW-1){1'b0}}, bus.s_axis_in_tvalid};
    else if (win_end)
      sample_cnt <= WIN_RECENTER;
    else if ((state != SEARCH) && bus.s_axis_in_tvalid)
      sample_cnt <= sample_cnt + 1'b1;
  end

  // Subcarrier counter for the skip and pass phases of the SSS symbol.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)
      sss_cnt <= '0;
    else if ((state == WAIT_SYM) && bus.SSS_start_i)
      sss_cnt <= '0;
    else if (skip_done)
      sss_cnt <= '0;
    else if (((state == SKIP) || (state == PASS)) && bus.SSS_valid_i)
      sss_cnt <= sss_cnt + 1'b1;
  end

  // Acquisition watchdog: cycles since the accepted peak.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)   to_cnt <= '0;
    else if (accept) to_cnt <= '0;
    else if (in_acq) to_cnt <= to_cnt + 1'b1;
  end

  // Consecutive window misses while tracking.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)              miss_cnt <= '0;
    else if (nid_hit && nid_ok) miss_cnt <= '0;
    else if (win_end)           miss_cnt <= miss_cnt + 1'b1;
  end

  // Registered pulses, latched identities and lock flag.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ssb_start_q    <= 1'b0;
      n_id_2_valid_q <= 1'b0;
      n_id_2_q       <= '0;
      n_id_valid_q   <= 1'b0;
      n_id_q         <= '0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      ssb_start_q    <= accept;
      n_id_2_valid_q <= accept && (state == SEARCH);
      n_id_valid_q   <= nid_hit;
      timeout_q      <= to_hit;
      if (accept && (state == SEARCH)) n_id_2_q <= bus.N_id_2_i;
      if (nid_hit) n_id_q <= nid_calc;
      if (nid_hit)                 locked_q <= nid_ok;
      else if (to_hit || miss_last) locked_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ssb_sync_controller.sv
// Self-checking bench for ssb_sync_controller: vector table of acquisitions,
// N_id scoreboard, and hand-written timeout/tracking/reset sequences.
module tb_ssb_sync_controller;
  localparam int P  = 2000;
  localparam int W  = 8;
  localparam int TO = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ssb_sync_controller_if bus();

  ssb_sync_controller #(
    .SSS_START(64), .SSS_LEN(127), .SSB_PERIOD(P), .WINDOW_HALF(W),
    .MAX_MISSES(3), .SSS_TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .reset_ni(rst_n), .bus(bus.slave)
  );

  typedef struct {
    logic [1:0] n2;
    logic [8:0] n1;
    int         exp_nid;
  } vec_t;

  vec_t       vecs [4];
  int         checks = 0, failures = 0;
  int         cyc = 0;
  int         pushed = 0, popped = 0;
  logic [9:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // N_id scoreboard: every result pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.N_id_valid_o) begin
      if (exp_q.size() == 0) chk("nid_unexpected", 1, 0);
      else begin
        popped++;
        chk("nid_value", int'(bus.N_id_o), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.peak_detected_i = 1'b0; bus.SSS_start_i = 1'b0;
    bus.SSS_valid_i = 1'b0; bus.N_id_1_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_peak(input logic [1:0] n2, output int t0);
    bus.peak_detected_i = 1'b1; bus.N_id_2_i = n2;
    @(negedge clk);
    bus.peak_detected_i = 1'b0;
    t0 = cyc;
  endtask

  // SSS_start then n strobes; tallies forwarded strobes and misplacements.
  task automatic sss_run(input int n, input bit gaps, output int fwd, output int bad);
    bit exp;
    fwd = 0; bad = 0;
    bus.SSS_start_i = 1'b1;
    @(negedge clk);
    bus.SSS_start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.SSS_valid_i = 1'b1;
      #1;
      exp = (i >= 64) && (i <= 190);
      if (bus.SSS_valid_o) fwd++;
      if (bus.SSS_valid_o != exp) bad++;
      @(negedge clk);
      bus.SSS_valid_i = 1'b0;
    end
  endtask

  task automatic nid_run(input logic [8:0] n1, input int exp);
    exp_q.push_back(10'(exp));
    pushed++;
    bus.N_id_1_i = n1; bus.N_id_1_valid_i = 1'b1;
    @(negedge clk);
    bus.N_id_1_valid_i = 1'b0;
  endtask

  // Full acquisition from SEARCH ending locked in TRACK_WAIT.
  task automatic acquire(input logic [1:0] n2, input logic [8:0] n1,
                         input int exp, output int t0);
    int fwd, bad;
    start_peak(n2, t0);
    chk("acq_ssb_start", bus.SSB_start_o, 1);
    chk("acq_nid2_valid", bus.N_id_2_valid_o, 1);
    chk("acq_nid2", bus.N_id_2_o, n2);
    chk("acq_state_wait_sym", bus.state_o, 1);
    @(negedge clk);
    chk("acq_ssb_start_1cyc", bus.SSB_start_o, 0);
    sss_run(200, 1'b1, fwd, bad);
    chk("acq_sss_fwd", fwd, 127);
    chk("acq_sss_bad", bad, 0);
    chk("acq_state_wait_nid1", bus.state_o, 4);
    nid_run(n1, exp);
    chk("acq_nid_valid", bus.N_id_valid_o, 1);
    chk("acq_locked", bus.locked_o, 1);
    chk("acq_state_track", bus.state_o, 5);
  endtask

  initial begin
    int t0, fwd, bad;
    bus.s_axis_in_tvalid = 1'b1;
    bus.peak_detected_i = 1'b0; bus.N_id_2_i = '0;
    bus.SSS_start_i = 1'b0; bus.SSS_valid_i = 1'b0;
    bus.N_id_1_i = '0; bus.N_id_1_valid_i = 1'b0;
    vecs[0] = '{2'd2, 9'd100, 302};
    vecs[1] = '{2'd0, 9'd0,   0};
    vecs[2] = '{2'd1, 9'd335, 1006};
    vecs[3] = '{2'd3, 9'd511, 512};

    // reset state
    #1;
    chk("rst_ssb_start", bus.SSB_start_o, 0);
    chk("rst_nid_valid", bus.N_id_valid_o, 0);
    chk("rst_nid", bus.N_id_o, 0);
    chk("rst_locked", bus.locked_o, 0);
    chk("rst_state", bus.state_o, 0);
    chk("rst_timeout", bus.timeout_o, 0);

    // acquisition vectors
    for (int v = 0; v < 4; v++) begin
      do_reset();
      acquire(vecs[v].n2, vecs[v].n1, vecs[v].exp_nid, t0);
    end

    // timeout with no SSS symbol
    do_reset();
    start_peak(2'd2, t0);
    wait_cyc(t0 + TO);
    chk("to_not_early", bus.timeout_o, 0);
    chk("to_state_before", bus.state_o, 1);
    @(negedge clk);
    chk("to_pulse", bus.timeout_o, 1);
    chk("to_state_search", bus.state_o, 0);
    chk("to_unlocked", bus.locked_o, 0);
    @(negedge clk);
    chk("to_pulse_1cyc", bus.timeout_o, 0);

    // result on the timeout cycle wins
    do_reset();
    start_peak(2'd2, t0);
    @(negedge clk);
    sss_run(191, 1'b0, fwd, bad);
    chk("tr_sss_fwd", fwd, 127);
    chk("tr_state_wait_nid1", bus.state_o, 4);
    wait_cyc(t0 + TO);
    nid_run(9'd7, 23);
    chk("tr_no_timeout", bus.timeout_o, 0);
    chk("tr_nid_valid", bus.N_id_valid_o, 1);
    chk("tr_locked", bus.locked_o, 1);

    // tracking window edges, then N_id change
    do_reset();
    acquire(2'd2, 9'd100, 302, t0);
    wait_cyc(t0 + P - W - 2);
    chk("win_state_wait", bus.state_o, 5);
    bus.peak_detected_i = 1'b1; bus.N_id_2_i = 2'd2;
    @(negedge clk);
    chk("win_early_ignored", bus.SSB_start_o, 0);
    chk("win_state_open", bus.state_o, 6);
    @(negedge clk);
    bus.peak_detected_i = 1'b0;
    chk("win_open_accept", bus.SSB_start_o, 1);
    chk("win_open_no_nid2_valid", bus.N_id_2_valid_o, 0);
    chk("win_open_state", bus.state_o, 1);
    t0 = cyc;
    @(negedge clk);
    sss_run(200, 1'b1, fwd, bad);
    chk("win_sss_fwd", fwd, 127);
    nid_run(9'd100, 302);
    chk("win_relock", bus.locked_o, 1);
    wait_cyc(t0 + P + W - 1);
    bus.peak_detected_i = 1'b1; bus.N_id_2_i = 2'd2;
    @(negedge clk);
    bus.peak_detected_i = 1'b0;
    chk("win_end_accept", bus.SSB_start_o, 1);
    chk("win_end_state", bus.state_o, 1);
    chk("win_end_locked", bus.locked_o, 1);
    @(negedge clk);
    sss_run(200, 1'b1, fwd, bad);
    nid_run(9'd101, 305);
    chk("nidchg_unlocked", bus.locked_o, 0);
    chk("nidchg_search", bus.state_o, 0);

    // misses, first window carrying a wrong-N_id_2 peak
    do_reset();
    acquire(2'd2, 9'd100, 302, t0);
    wait_cyc(t0 + P - 1);
    bus.peak_detected_i = 1'b1; bus.N_id_2_i = 2'd1;
    @(negedge clk);
    bus.peak_detected_i = 1'b0;
    chk("miss_wrong_nid2_ignored", bus.SSB_start_o, 0);
    wait_cyc(t0 + P + W);
    chk("miss_first_state", bus.state_o, 5);
    chk("miss_first_locked", bus.locked_o, 1);
    while ((bus.state_o != 3'd0) && (cyc < t0 + 7000)) @(negedge clk);
    chk("miss_search_cycle", cyc - t0, 6010);
    chk("miss_unlocked", bus.locked_o, 0);

    // asynchronous reset mid-PASS
    do_reset();
    start_peak(2'd2, t0);
    @(negedge clk);
    sss_run(100, 1'b0, fwd, bad);
    bus.SSS_valid_i = 1'b1;
    #1;
    chk("mid_pass_fwd", bus.SSS_valid_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sss_valid", bus.SSS_valid_o, 0);
    chk("arst_state", bus.state_o, 0);
    chk("arst_nid2", bus.N_id_2_o, 0);
    chk("arst_ssb_start", bus.SSB_start_o, 0);
    @(negedge clk);
    bus.SSS_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    acquire(2'd1, 9'd50, 151, t0);

    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);
    chk("sb_count", popped, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
